// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 64-bit ALU between NUM_REQ requesters.
// Define HIVEK_ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module alu_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned TAG_W   = 4,
  localparam int unsigned OP_W    = 4,
  localparam int unsigned DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [OP_W-1:0]           alu_sel,
  output logic [DATA_W-1:0]         alu_src1,
  output logic [DATA_W-1:0]         alu_src2,
  input  logic [DATA_W-1:0]         alu_dst,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [TAG_W-1:0]          rsp_tag
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic              iss_valid;
  logic [OP_W-1:0]   iss_sel;
  logic [DATA_W-1:0] iss_src1;
  logic [DATA_W-1:0] iss_src2;
  logic [TAG_W-1:0]  iss_tag;
  logic [ID_W-1:0]   iss_id;

  logic              rsp_vld;
  logic [ID_W-1:0]   rsp_id;

  logic              rsp_fire;
  logic              rsp_free;
  logic              iss_free;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic              accept;

  assign rsp_fire = rsp_vld && rsp_ready[rsp_id];
  assign rsp_free = !rsp_vld || rsp_fire;
  assign iss_free = !iss_valid || rsp_free;
  assign accept   = gnt_found && iss_free;

`ifdef HIVEK_ALU_ARB_FIXED_PRIO_EN
  // Lowest index wins; scanning downward lets the last match take priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;

  // Search starts one past the last winner; the smallest offset wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = ID_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      ptr <= gnt_id;
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_vld) rsp_valid[rsp_id] = 1'b1;
  end

  assign alu_sel  = iss_sel;
  assign alu_src1 = iss_src1;
  assign alu_src2 = iss_src2;

  // Issue stage: loads the winner, empties when its result moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_sel   <= '0;
      iss_src1  <= '0;
      iss_src2  <= '0;
      iss_tag   <= '0;
      iss_id    <= '0;
    end else begin
      if (iss_free) iss_valid <= accept;
      if (accept) begin
        iss_sel  <= req_sel[32'(gnt_id)*OP_W +: OP_W];
        iss_src1 <= req_src1[32'(gnt_id)*DATA_W +: DATA_W];
        iss_src2 <= req_src2[32'(gnt_id)*DATA_W +: DATA_W];
        iss_tag  <= req_tag[32'(gnt_id)*TAG_W +: TAG_W];
        iss_id   <= gnt_id;
      end
    end
  end

  // Response stage: captures the ALU result and holds it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_id   <= '0;
    end else if (iss_valid && rsp_free) begin
      rsp_vld  <= 1'b1;
      rsp_data <= alu_dst;
      rsp_tag  <= iss_tag;
      rsp_id   <= iss_id;
    end else if (rsp_fire) begin
      rsp_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: bench-side ALU, scoreboard of accepted requests,
// and per-scenario directed checks. Honours HIVEK_ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned TW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*4-1:0]    req_sel = '0;
  logic [N*64-1:0]   req_src1 = '0;
  logic [N*64-1:0]   req_src2 = '0;
  logic [N*TW-1:0]   req_tag = '0;
  logic [3:0]        alu_sel;
  logic [63:0]       alu_src1;
  logic [63:0]       alu_src2;
  logic [63:0]       alu_dst;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [63:0]       rsp_data;
  logic [TW-1:0]     rsp_tag;

  typedef struct packed {
    logic [0:0]    id;
    logic [TW-1:0] tag;
    logic [63:0]   data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_mode = 1'b0;

  alu_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .alu_sel(alu_sel), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_dst(alu_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  function automatic logic [63:0] alu_model(input logic [3:0] s, input logic [63:0] a,
                                            input logic [63:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {63'd0, $signed(a) < $signed(b)};
      4'd6:    return {63'd0, a < b};
      default: return a;
    endcase
  endfunction

  assign alu_dst = alu_model(alu_sel, alu_src1, alu_src2);

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [0:0] rid;
    if (rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = 1'(i);
          e.tag  = req_tag[i*TW +: TW];
          e.data = alu_model(req_sel[i*4 +: 4], req_src1[i*64 +: 64], req_src2[i*64 +: 64]);
          sb.push_back(e);
        end
      end
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          errors++;
          $display("FAIL req_ready_onehot: got %b valid %b", req_ready, req_valid);
        end
      end
      if (rsp_valid != '0) begin
        checks++;
        if ($countones(rsp_valid) != 1) begin
          errors++;
          $display("FAIL rsp_valid_onehot: got %b", rsp_valid);
        end else begin
          rid = rsp_valid[1] ? 1'b1 : 1'b0;
          if (rsp_ready[rid]) begin
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected: rsp id %0d data %h tag %h with empty queue",
                       rid, rsp_data, rsp_tag);
            end else begin
              e = sb.pop_front();
              if (rid !== e.id || rsp_tag !== e.tag || rsp_data !== e.data) begin
                errors++;
                $display("FAIL sb_rsp: got id %0d tag %h data %h expected id %0d tag %h data %h",
                         rid, rsp_tag, rsp_data, e.id, e.tag, e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic rand_slot(input int i);
    req_sel[i*4 +: 4]    = 4'($urandom_range(0, 9));
    req_src1[i*64 +: 64] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3))
                                                       : {$urandom, $urandom};
    req_src2[i*64 +: 64] = {$urandom, $urandom};
  endtask

  // Called at a negedge: moves to just after the next posedge and refreshes accepted slots.
  task automatic advance();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (acc[i]) begin
        req_tag[i*TW +: TW] = req_tag[i*TW +: TW] + 1'b1;
        if (rand_mode) rand_slot(i);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      advance();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_valid: rsp_valid %b req_ready %b expected 0", rsp_valid, req_ready);
    end
    checks++;
    if (alu_sel !== 4'd0 || alu_src1 !== 64'd0 || alu_src2 !== 64'd0) begin
      errors++;
      $display("FAIL reset_alu: sel %h src1 %h src2 %h expected 0", alu_sel, alu_src1, alu_src2);
    end
    checks++;
    if (rsp_data !== 64'd0 || rsp_tag !== '0) begin
      errors++;
      $display("FAIL reset_rsp: data %h tag %h expected 0", rsp_data, rsp_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    rsp_ready       = 2'b11;
    req_sel[3:0]    = 4'd0;
    req_src1[63:0]  = 64'd5;
    req_src2[63:0]  = 64'd7;
    req_tag[3:0]    = 4'd3;
    req_valid       = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || alu_src1 !== 64'd5 || alu_src2 !== 64'd7) begin
      errors++;
      $display("FAIL single_issue: rsp_valid %b src1 %h src2 %h expected 00/5/7",
               rsp_valid, alu_src1, alu_src2);
    end
    advance();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'd12 || rsp_tag !== 4'd3) begin
      errors++;
      $display("FAIL single_rsp: valid %b data %0d tag %0d expected 01/12/3",
               rsp_valid, rsp_data, rsp_tag);
    end
    advance();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_done: rsp_valid %b expected 00", rsp_valid);
    end
    advance();
  endtask

  task automatic test_alternate();
    int g;
    int rg;
    apply_reset();
    rsp_ready        = 2'b11;
    req_sel[3:0]     = 4'd1;
    req_src1[63:0]   = 64'd10;
    req_src2[63:0]   = 64'd3;
    req_tag[3:0]     = 4'd0;
    req_sel[7:4]     = 4'd5;
    req_src1[127:64] = '1;
    req_src2[127:64] = 64'd0;
    req_tag[7:4]     = 4'd8;
    req_valid        = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
`ifdef HIVEK_ALU_ARB_FIXED_PRIO_EN
      g  = 0;
      rg = 0;
`else
      g  = k % 2;
      rg = (k + 2) % 2;
`endif
      checks++;
      if (req_ready !== 2'(1 << g)) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b expected %b", k, req_ready, 2'(1 << g));
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 2'(1 << rg) || rsp_data !== ((rg == 0) ? 64'd7 : 64'd1)) begin
          errors++;
          $display("FAIL alt_rsp[%0d]: valid %b data %0d expected %b/%0d", k, rsp_valid,
                   rsp_data, 2'(1 << rg), (rg == 0) ? 7 : 1);
        end
      end
      advance();
    end
    req_valid = 2'b00;
    drain(3);
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready        = 2'b10;
    req_sel[3:0]     = 4'd0;
    req_src1[63:0]   = 64'd100;
    req_src2[63:0]   = 64'd23;
    req_tag[3:0]     = 4'd5;
    req_sel[7:4]     = 4'd4;
    req_src1[127:64] = 64'hF0F0;
    req_src2[127:64] = 64'h0FF0;
    req_tag[7:4]     = 4'd9;
    req_valid        = 2'b11;
    drain(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b expected 00", k, req_ready);
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 64'd123 || rsp_tag !== 4'd5) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid %b data %0d tag %0d expected 01/123/5",
                 k, rsp_valid, rsp_data, rsp_tag);
      end
      advance();
    end
    rsp_ready = 2'b11;
    drain(4);
    req_valid = 2'b00;
    drain(4);
  endtask

  task automatic test_edge_ops();
    rsp_ready        = 2'b11;
    req_sel[7:4]     = 4'd6;
    req_src1[127:64] = '1;
    req_src2[127:64] = 64'd1;
    req_tag[7:4]     = 4'd2;
    req_valid        = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL edge_ready0: got %b expected 10", req_ready);
    end
    advance();
    req_sel[7:4]     = 4'd9;
    req_src1[127:64] = 64'hABCD;
    req_src2[127:64] = {$urandom, $urandom};
    req_tag[7:4]     = 4'd6;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL edge_ready1: got %b expected 10", req_ready);
    end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'd0 || rsp_tag !== 4'd2) begin
      errors++;
      $display("FAIL edge_sltu: valid %b data %h tag %0d expected 10/0/2",
               rsp_valid, rsp_data, rsp_tag);
    end
    advance();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'hABCD || rsp_tag !== 4'd6) begin
      errors++;
      $display("FAIL edge_pass: valid %b data %h tag %0d expected 10/abcd/6",
               rsp_valid, rsp_data, rsp_tag);
    end
    advance();
    drain(2);
  endtask

  task automatic test_random();
    rand_mode = 1'b1;
    for (int i = 0; i < int'(N); i++) rand_slot(i);
    for (int k = 0; k < 300; k++) begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      @(negedge clk);
      advance();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    drain(4);
    rand_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsp_ready        = 2'b00;
    req_sel[3:0]     = 4'd3;
    req_src1[63:0]   = 64'h11;
    req_src2[63:0]   = 64'h22;
    req_sel[7:4]     = 4'd2;
    req_src1[127:64] = 64'hFF;
    req_src2[127:64] = 64'h0F;
    req_valid        = 2'b11;
    drain(3);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || alu_src1 !== 64'd0) begin
      errors++;
      $display("FAIL midreset_clear: rsp_valid %b req_ready %b src1 %h expected 0",
               rsp_valid, req_ready, alu_src1);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b expected 01", req_ready);
    end
    advance();
    drain(5);
    req_valid = 2'b00;
    drain(4);
  endtask

  task automatic test_drained();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || rsp_valid != '0) && budget < 40) begin
      @(negedge clk);
      advance();
      budget++;
    end
    checks++;
    if (sb.size() != 0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL drained: %0d responses outstanding, rsp_valid %b", sb.size(), rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_edge_ops();
    test_random();
    test_reset_mid();
    test_drained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
